uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_tx_sched_if.sv | 52 +++++
 rtl/uart_sync_fifo.sv | 67 ++++++
 rtl/uart_tx_sched.sv | 192 +++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART transmit scheduler:
//                FSM state encoding, launch-watchdog length, default depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Scheduler states; explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    // Cycles WAIT_BUSY tolerates tx_busy staying low before giving up
    localparam int WAIT_BUSY_TIMEOUT = 4;

    // Default FIFO depth in bytes
    localparam int DEFAULT_DEPTH = 16;

    // Byte width carried through the FIFO
    localparam int DATA_W = 8;

    // True when value is a positive power of two
    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_sched_if
//  Description : Bus-side and transmitter-side signals of the UART transmit
//                scheduler. master = bus/transmitter side, slave = scheduler.
//                irq exists only when UART_TX_SCHED_IRQ_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_sched_if
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              flush;
    logic              clr_ovf;
    logic              tx_busy;
    logic              tx_en;
    logic [DATA_W-1:0] tx_data;
    logic              full;
    logic              empty;
    logic [LVL_W-1:0]  level;
    logic              overflow;
`ifdef UART_TX_SCHED_IRQ_EN
    logic              irq;

    modport master (
        output wr_en, wr_data, flush, clr_ovf, tx_busy,
        input  tx_en, tx_data, full, empty, level, overflow, irq
    );

    modport slave (
        input  wr_en, wr_data, flush, clr_ovf, tx_busy,
        output tx_en, tx_data, full, empty, level, overflow, irq
    );
`else
    modport master (
        output wr_en, wr_data, flush, clr_ovf, tx_busy,
        input  tx_en, tx_data, full, empty, level, overflow
    );

    modport slave (
        input  wr_en, wr_data, flush, clr_ovf, tx_busy,
        output tx_en, tx_data, full, empty, level, overflow
    );
`endif

endinterface
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync_fifo
//  Description : Single-clock byte FIFO with synchronous flush. Callers only
//                issue push when there is room (or a same-cycle pop) and pop
//                when non-empty; flush overrides both.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DATA_W
) (
    input  logic                   clk,
    input  logic                   RSTn,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage array; a flushed push is never written
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); occupancy tracked alongside
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_sched
//  Description : Buffers bytes from the UART bus side and launches them one at
//                a time into the transmitter, pacing on tx_busy. A watchdog
//                in WAIT_BUSY recovers from a transmitter that never starts.
//                Optional low-water interrupt: define UART_TX_SCHED_IRQ_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int IRQ_THRESH = 4
) (
    input  logic           clk,
    input  logic           RSTn,
    uart_tx_sched_if.slave bus
);

    localparam int                LVL_W     = $clog2(DEPTH) + 1;
    localparam int                CNT_W     = $clog2(WAIT_BUSY_TIMEOUT + 1);
    localparam logic [LVL_W-1:0]  DEPTH_LVL = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(WAIT_BUSY_TIMEOUT - 1);

    // Reject unusable parameterisations at elaboration
    generate
        if (!is_pow2(DEPTH) || DEPTH < 2 || IRQ_THRESH < 0 || IRQ_THRESH > DEPTH) begin : g_bad_params
            $error("uart_tx_sched: DEPTH must be a power of two >= 2 and IRQ_THRESH within 0..DEPTH");
        end
    endgenerate

    state_t              state;
    state_t              state_nxt;
    logic                launch;
    logic [CNT_W-1:0]    wait_cnt;
    logic [DATA_W-1:0]   head;
    logic [DATA_W-1:0]   tx_data;
    logic [LVL_W-1:0]    level;
    logic                full;
    logic                empty;
    logic                overflow;
    logic                push_ok;
    logic                pop_ok;
    logic                drop;

    assign full  = (level == DEPTH_LVL);
    assign empty = (level == '0);

    // The head leaves the FIFO during the LAUNCH cycle; flush discards it instead
    assign pop_ok  = (state == ST_LAUNCH) && !empty && !bus.flush;
    // A full FIFO still accepts a byte when the head leaves in the same cycle
    assign push_ok = bus.wr_en && !bus.flush && (!full || pop_ok);
    assign drop    = bus.wr_en && !bus.flush && full && !pop_ok;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .RSTn    (RSTn),
        .push    (push_ok),
        .pop     (pop_ok),
        .flush   (bus.flush),
        .wr_data (bus.wr_data),
        .rd_data (head),
        .level   (level)
    );

    // State register
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and launch strobe; flush blocks a launch so a cleared FIFO never relaunches
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty && !bus.tx_busy && !bus.flush) begin
                    state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                launch    = 1'b1;
                state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_nxt = ST_WAIT_DONE;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Counts cycles spent waiting for the transmitter to acknowledge a launch
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            wait_cnt <= '0;
        end else if (state != ST_WAIT_BUSY) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Capture the head on entry to LAUNCH so the byte is valid alongside tx_en
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            tx_data <= '0;
        end else if (state == ST_IDLE && state_nxt == ST_LAUNCH) begin
            tx_data <= head;
        end
    end

    // Sticky overflow; a new drop outranks a same-cycle clear
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (bus.clr_ovf) begin
            overflow <= 1'b0;
        end
    end

`ifdef UART_TX_SCHED_IRQ_EN
    localparam logic [LVL_W-1:0] IRQ_LVL = LVL_W'(IRQ_THRESH);

    logic [LVL_W-1:0] level_nxt;
    logic             empty_latched;
    logic             empty_latched_nxt;
    logic             irq;

    // Occupancy after this edge, so irq lines up with level instead of lagging it
    always_comb begin
        level_nxt = level;
        if (bus.flush) begin
            level_nxt = '0;
        end else if (push_ok && !pop_ok) begin
            level_nxt = level + LVL_W'(1);
        end else if (!push_ok && pop_ok) begin
            level_nxt = level - LVL_W'(1);
        end
    end

    // Remembers a drain until the next accepted push
    always_comb begin
        empty_latched_nxt = empty_latched;
        if (push_ok) begin
            empty_latched_nxt = 1'b0;
        end else if (level_nxt == '0) begin
            empty_latched_nxt = 1'b1;
        end
    end

    // Low-water interrupt, silent once the FIFO has fully drained
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            empty_latched <= 1'b1;
            irq           <= 1'b0;
        end else begin
            empty_latched <= empty_latched_nxt;
            irq           <= (level_nxt <= IRQ_LVL) && !empty_latched_nxt;
        end
    end

    assign bus.irq = irq;
`endif

    assign bus.tx_en    = launch;
    assign bus.tx_data  = tx_data;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.level    = level;
    assign bus.overflow = overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_sched
//  Description : Directed self-checking bench for uart_tx_sched (DEPTH=16,
//                IRQ_THRESH=4). Inputs change and outputs are sampled on the
//                falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

    logic       clk;
    logic       RSTn;
    logic       busy_force;
    logic       model_en;
    logic [3:0] model_cnt;
    logic       model_busy;
    int         tests;
    int         fails;

    uart_tx_sched_if #(.DEPTH(16)) bus_if ();

    uart_tx_sched #(
        .DEPTH      (16),
        .IRQ_THRESH (4)
    ) dut (
        .clk  (clk),
        .RSTn (RSTn),
        .bus  (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model: busy for 10 cycles starting the cycle after tx_en
    always @(posedge clk or negedge RSTn) begin
        if (!RSTn)
            model_cnt <= 4'd0;
        else if (model_en && bus_if.tx_en)
            model_cnt <= 4'd10;
        else if (model_cnt != 4'd0)
            model_cnt <= model_cnt - 4'd1;
    end
    assign model_busy     = (model_cnt != 4'd0);
    assign bus_if.tx_busy = busy_force | model_busy;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        RSTn = 1'b0; busy_force = 1'b0; model_en = 1'b0;
        bus_if.wr_en = 1'b0; bus_if.wr_data = 8'h00; bus_if.flush = 1'b0; bus_if.clr_ovf = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (bus_if.empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b want 1", bus_if.empty); end
        tests++; if (bus_if.full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b want 0", bus_if.full); end
        tests++; if (bus_if.level !== 5'd0) begin fails++; $display("FAIL reset_level: got %0d want 0", bus_if.level); end
        tests++; if (bus_if.overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b want 0", bus_if.overflow); end
        tests++; if (bus_if.tx_en !== 1'b0) begin fails++; $display("FAIL reset_tx_en: got %b want 0", bus_if.tx_en); end
        tests++; if (bus_if.tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %h want 00", bus_if.tx_data); end
`ifdef UART_TX_SCHED_IRQ_EN
        tests++; if (bus_if.irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b want 0", bus_if.irq); end
`endif
        RSTn = 1'b1;
    endtask

    task automatic test_latency();
        @(negedge clk); bus_if.wr_en = 1'b1; bus_if.wr_data = 8'h55;
        @(negedge clk); bus_if.wr_en = 1'b0;
        tests++; if (bus_if.level !== 5'd1) begin fails++; $display("FAIL lat_level1: got %0d want 1", bus_if.level); end
        tests++; if (bus_if.tx_en !== 1'b0) begin fails++; $display("FAIL lat_early_tx_en: got %b want 0", bus_if.tx_en); end
        @(negedge clk);
        tests++; if (bus_if.tx_en !== 1'b1) begin fails++; $display("FAIL lat_tx_en: got %b want 1", bus_if.tx_en); end
        tests++; if (bus_if.tx_data !== 8'h55) begin fails++; $display("FAIL lat_tx_data: got %h want 55", bus_if.tx_data); end
        @(negedge clk);
        tests++; if (bus_if.tx_en !== 1'b0) begin fails++; $display("FAIL lat_pulse_width: got %b want 0", bus_if.tx_en); end
        tests++; if (bus_if.level !== 5'd0) begin fails++; $display("FAIL lat_level0: got %0d want 0", bus_if.level); end
        tests++; if (bus_if.tx_data !== 8'h55) begin fails++; $display("FAIL lat_tx_data_hold: got %h want 55", bus_if.tx_data); end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] got [3];
        int         npulse;
        int         fall;
        int         last_pulse;
        logic       prev_busy;
        npulse = 0; fall = -1; last_pulse = -1; prev_busy = 1'b0;
        got[0] = 8'h00; got[1] = 8'h00; got[2] = 8'h00;
        model_en = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (prev_busy && !bus_if.tx_busy) fall = cyc;
            prev_busy = bus_if.tx_busy;
            if (bus_if.tx_en === 1'b1) begin
                if (npulse < 3) got[npulse] = bus_if.tx_data;
                if (npulse > 0) begin
                    tests++;
                    if (fall <= last_pulse || cyc - fall < 2) begin
                        fails++;
                        $display("FAIL b2b_gap%0d: tx_en at %0d, busy fall at %0d, previous tx_en at %0d, want fall after it and gap >= 2", npulse, cyc, fall, last_pulse);
                    end
                end
                last_pulse = cyc;
                npulse++;
            end
            bus_if.wr_en = (cyc < 3);
            bus_if.wr_data = 8'hA1 + 8'(cyc);
        end
        bus_if.wr_en = 1'b0;
        model_en = 1'b0;
        tests++; if (npulse != 3) begin fails++; $display("FAIL b2b_count: got %0d pulses want 3", npulse); end
        tests++; if (got[0] !== 8'hA1) begin fails++; $display("FAIL b2b_data0: got %h want a1", got[0]); end
        tests++; if (got[1] !== 8'hA2) begin fails++; $display("FAIL b2b_data1: got %h want a2", got[1]); end
        tests++; if (got[2] !== 8'hA3) begin fails++; $display("FAIL b2b_data2: got %h want a3", got[2]); end
        tests++; if (bus_if.empty !== 1'b1) begin fails++; $display("FAIL b2b_empty: got %b want 1", bus_if.empty); end
    endtask

    task automatic test_overflow();
        @(negedge clk); busy_force = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
`ifdef UART_TX_SCHED_IRQ_EN
            if (i == 1) begin
                tests++; if (bus_if.irq !== 1'b1) begin fails++; $display("FAIL irq_low_water: got %b want 1", bus_if.irq); end
            end
`endif
            if (i == 16) begin
                tests++; if (bus_if.full !== 1'b1) begin fails++; $display("FAIL ovf_full_at16: got %b want 1", bus_if.full); end
                tests++; if (bus_if.overflow !== 1'b0) begin fails++; $display("FAIL ovf_early: got %b want 0", bus_if.overflow); end
`ifdef UART_TX_SCHED_IRQ_EN
                tests++; if (bus_if.irq !== 1'b0) begin fails++; $display("FAIL irq_high_level: got %b want 0", bus_if.irq); end
`endif
            end
            bus_if.wr_en = 1'b1; bus_if.wr_data = 8'h10 + 8'(i);
        end
        @(negedge clk); bus_if.wr_en = 1'b0;
        tests++; if (bus_if.full !== 1'b1) begin fails++; $display("FAIL ovf_full: got %b want 1", bus_if.full); end
        tests++; if (bus_if.overflow !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b want 1", bus_if.overflow); end
        tests++; if (bus_if.level !== 5'd16) begin fails++; $display("FAIL ovf_level: got %0d want 16", bus_if.level); end
        // Drop and clear in the same cycle: the set must win
        bus_if.wr_en = 1'b1; bus_if.wr_data = 8'h77; bus_if.clr_ovf = 1'b1;
        @(negedge clk); bus_if.wr_en = 1'b0; bus_if.clr_ovf = 1'b0;
        tests++; if (bus_if.overflow !== 1'b1) begin fails++; $display("FAIL ovf_set_beats_clr: got %b want 1", bus_if.overflow); end
        bus_if.clr_ovf = 1'b1;
        @(negedge clk); bus_if.clr_ovf = 1'b0;
        tests++; if (bus_if.overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b want 0", bus_if.overflow); end
    endtask

    task automatic test_full_push_pop();
        busy_force = 1'b0;
        @(negedge clk);
        tests++; if (bus_if.tx_en !== 1'b1) begin fails++; $display("FAIL fpp_launch: got %b want 1", bus_if.tx_en); end
        tests++; if (bus_if.tx_data !== 8'h10) begin fails++; $display("FAIL fpp_head: got %h want 10", bus_if.tx_data); end
        bus_if.wr_en = 1'b1; bus_if.wr_data = 8'hEE;
        @(negedge clk); bus_if.wr_en = 1'b0;
        tests++; if (bus_if.level !== 5'd16) begin fails++; $display("FAIL fpp_level: got %0d want 16", bus_if.level); end
        tests++; if (bus_if.overflow !== 1'b0) begin fails++; $display("FAIL fpp_overflow: got %b want 0", bus_if.overflow); end
        tests++; if (bus_if.tx_en !== 1'b0) begin fails++; $display("FAIL fpp_pulse_width: got %b want 0", bus_if.tx_en); end
    endtask

    task automatic test_timeout();
        int seen;
        seen = -1;
        for (int k = 2; k <= 20; k++) begin
            @(negedge clk);
            if (bus_if.tx_en === 1'b1) begin seen = k; break; end
        end
        tests++; if (seen != 6) begin fails++; $display("FAIL timeout_relaunch: next tx_en after %0d cycles want 6", seen); end
        tests++; if (bus_if.tx_data !== 8'h11) begin fails++; $display("FAIL timeout_data: got %h want 11", bus_if.tx_data); end
        busy_force = 1'b1;
        @(negedge clk);
        tests++; if (bus_if.level !== 5'd15) begin fails++; $display("FAIL timeout_level: got %0d want 15", bus_if.level); end
    endtask

    task automatic test_async_reset();
        @(negedge clk); #2 RSTn = 1'b0;
        #1;
        tests++; if (bus_if.level !== 5'd0) begin fails++; $display("FAIL arst_level: got %0d want 0", bus_if.level); end
        tests++; if (bus_if.empty !== 1'b1) begin fails++; $display("FAIL arst_empty: got %b want 1", bus_if.empty); end
        tests++; if (bus_if.tx_data !== 8'h00) begin fails++; $display("FAIL arst_tx_data: got %h want 00", bus_if.tx_data); end
        @(negedge clk); busy_force = 1'b0; RSTn = 1'b1;
        repeat (4) @(negedge clk);
        tests++; if (bus_if.tx_en !== 1'b0) begin fails++; $display("FAIL arst_no_resume: got %b want 0", bus_if.tx_en); end
    endtask

    task automatic test_flush();
        int pulses;
        pulses = 0;
        model_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); bus_if.wr_en = 1'b1; bus_if.wr_data = 8'hB0 + 8'(i);
        end
        @(negedge clk); bus_if.wr_en = 1'b0;
        tests++; if (bus_if.level !== 5'd5) begin fails++; $display("FAIL flush_pre_level: got %0d want 5", bus_if.level); end
        tests++; if (bus_if.tx_data !== 8'hB0) begin fails++; $display("FAIL flush_inflight_data: got %h want b0", bus_if.tx_data); end
        // Flush while the frame is in flight, with a competing push
        bus_if.flush = 1'b1; bus_if.wr_en = 1'b1; bus_if.wr_data = 8'hCC;
        @(negedge clk); bus_if.flush = 1'b0; bus_if.wr_en = 1'b0;
        tests++; if (bus_if.empty !== 1'b1) begin fails++; $display("FAIL flush_empty: got %b want 1", bus_if.empty); end
        tests++; if (bus_if.level !== 5'd0) begin fails++; $display("FAIL flush_level: got %0d want 0", bus_if.level); end
        tests++; if (bus_if.overflow !== 1'b0) begin fails++; $display("FAIL flush_overflow: got %b want 0", bus_if.overflow); end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus_if.tx_en === 1'b1) pulses++;
        end
        tests++; if (pulses != 0) begin fails++; $display("FAIL flush_no_relaunch: got %0d tx_en pulses want 0", pulses); end
        tests++; if (bus_if.tx_data !== 8'hB0) begin fails++; $display("FAIL flush_tx_data_hold: got %h want b0", bus_if.tx_data); end
`ifdef UART_TX_SCHED_IRQ_EN
        tests++; if (bus_if.irq !== 1'b0) begin fails++; $display("FAIL flush_irq: got %b want 0", bus_if.irq); end
`endif
        model_en = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_latency();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_timeout();
        test_async_reset();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
